// File: rtl/mining_nonce_scheduler_if.sv
// Bundle of control, block-request, digest and status signals exchanged between
// the nonce scheduler and its host / preprocessing / chunk-engine neighbours.
interface mining_nonce_scheduler_if #(
    parameter int CW = 32
);
    // host control
    logic          start;
    logic          abort;
    logic [CW-1:0] nonce_first;
    logic [CW-1:0] nonce_last;
    logic [255:0]  target;

    // block request towards preprocessing
    logic          blk_valid;
    logic          blk_ready;
    logic [15:0]   blk_addr;
    logic [CW-1:0] nonce;

    // digest from the chunk engine
    logic          hash_valid;
    logic [255:0]  hash_in;

    // status back to the host
    logic [2:0]    state;
    logic          busy;
    logic          done;
    logic          found;
    logic          err;
    logic [CW-1:0] found_nonce;
    logic [CW-1:0] hashes;

    // scheduler side
    modport slave (
        input  start, abort, nonce_first, nonce_last, target,
        input  blk_ready, hash_valid, hash_in,
        output blk_valid, blk_addr, nonce,
        output state, busy, done, found, err, found_nonce, hashes
    );

    // host / engine side
    modport master (
        output start, abort, nonce_first, nonce_last, target,
        output blk_ready, hash_valid, hash_in,
        input  blk_valid, blk_addr, nonce,
        input  state, busy, done, found, err, found_nonce, hashes
    );
endinterface

// File: rtl/mining_nonce_scheduler.sv
// Nonce scheduler for the SHA-256 mining datapath. For every nonce in the
// latched range it streams NUM_BLOCKS block requests by address, waits for the
// digest, and compares it against the target. The run ends on the first digest
// below the target, on range exhaustion, on an engine timeout, or on abort.
module mining_nonce_scheduler #(
    parameter int NUM_BLOCKS = 2,
    parameter int TIMEOUT    = 1024,
    parameter int CW         = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    mining_nonce_scheduler_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int              TW           = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]     LAST_BLOCK   = 16'(NUM_BLOCKS - 1);

    state_t          state_q,      state_d;
    logic [15:0]     blkAddr_q,    blkAddr_d;
    logic [CW-1:0]   nonce_q,      nonce_d;
    logic [CW-1:0]   nonceLast_q,  nonceLast_d;
    logic [255:0]    target_q,     target_d;
    logic [255:0]    hash_q,       hash_d;
    logic [TW-1:0]   timer_q,      timer_d;
    logic            found_q,      found_d;
    logic            err_q,        err_d;
    logic [CW-1:0]   foundNonce_q, foundNonce_d;
    logic [CW-1:0]   hashes_q,     hashes_d;
    logic            done_q,       done_d;

    // State and datapath registers; everything clears on the asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            blkAddr_q    <= '0;
            nonce_q      <= '0;
            nonceLast_q  <= '0;
            target_q     <= '0;
            hash_q       <= '0;
            timer_q      <= '0;
            found_q      <= 1'b0;
            err_q        <= 1'b0;
            foundNonce_q <= '0;
            hashes_q     <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            blkAddr_q    <= blkAddr_d;
            nonce_q      <= nonce_d;
            nonceLast_q  <= nonceLast_d;
            target_q     <= target_d;
            hash_q       <= hash_d;
            timer_q      <= timer_d;
            found_q      <= found_d;
            err_q        <= err_d;
            foundNonce_q <= foundNonce_d;
            hashes_q     <= hashes_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic; abort outranks start and every in-state transition.
    always_comb begin
        state_d      = state_q;
        blkAddr_d    = blkAddr_q;
        nonce_d      = nonce_q;
        nonceLast_d  = nonceLast_q;
        target_d     = target_q;
        hash_d       = hash_q;
        timer_d      = timer_q;
        found_d      = found_q;
        err_d        = err_q;
        foundNonce_d = foundNonce_q;
        hashes_d     = hashes_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    nonceLast_d = bus.nonce_last;
                    target_d    = bus.target;
                    nonce_d     = bus.nonce_first;
                    found_d     = 1'b0;
                    err_d       = 1'b0;
                    hashes_d    = '0;
                    blkAddr_d   = '0;
                    if (bus.nonce_first > bus.nonce_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end

            LOAD: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    blkAddr_d = '0;
                end else if (bus.blk_ready) begin
                    if (blkAddr_q == LAST_BLOCK) begin
                        blkAddr_d = '0;
                        timer_d   = '0;
                        state_d   = WAIT;
                    end else begin
                        blkAddr_d = blkAddr_q + 16'd1;
                    end
                end
            end

            WAIT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.hash_valid) begin
                    hash_d  = bus.hash_in;
                    state_d = CHECK;
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            CHECK: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    if (hashes_q != {CW{1'b1}}) begin
                        hashes_d = hashes_q + CW'(1);
                    end
                    if (hash_q < target_q) begin
                        found_d      = 1'b1;
                        foundNonce_d = nonce_q;
                        state_d      = DONE;
                        done_d       = 1'b1;
                    end else if (nonce_q == nonceLast_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        nonce_d = nonce_q + CW'(1);
                        state_d = LOAD;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.state       = state_q;
    assign bus.blk_valid   = (state_q == LOAD);
    assign bus.blk_addr    = blkAddr_q;
    assign bus.nonce       = nonce_q;
    assign bus.busy        = (state_q == LOAD) || (state_q == WAIT) || (state_q == CHECK);
    assign bus.done        = done_q;
    assign bus.found       = found_q;
    assign bus.err         = err_q;
    assign bus.found_nonce = foundNonce_q;
    assign bus.hashes      = hashes_q;

endmodule
